// File: rtl/ram1_responder.sv
// ram1_responder
//   Asynchronous-SRAM-style target that answers a 16-bit initiator on an
//   active-low EN/OE/WE bus. Every bus input is registered once. An FSM
//   works only on those sampled copies and serves reads (with a
//   programmable wait) and writes (buffered in a holding register until
//   WE rises) against 2^DEPTH_LOG2 x 16-bit internal storage.
//
// Parameters
//   DEPTH_LOG2 : word-address bits backed by storage
//   READ_LAT   : wait cycles between read acceptance and data drive (1..7)
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous active-low reset
//   Ram1Addr  : 18-bit word address
//   Ram1Data  : 16-bit bidirectional data, driven only in RD_DRIVE
//   Ram1OE    : output enable, active-low
//   Ram1WE    : write enable, active-low
//   Ram1EN    : chip enable, active-low
//   rd_count  : completed reads, saturating
//   wr_count  : committed writes, saturating
//   err       : sticky protocol/range error
//   state_o   : FSM state (IDLE=0, RD_WAIT=1, RD_DRIVE=2, WR_HOLD=3)

module ram1_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  input  logic        Ram1OE,
  input  logic        Ram1WE,
  input  logic        Ram1EN,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        err,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR_HOLD  = 2'd3
  } state_t;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  // Address bits above the backed storage must be zero.
  function automatic logic out_of_range(input logic [17:0] a);
    return |(a >> DEPTH_LOG2);
  endfunction

  // Sampled bus inputs
  logic [17:0] addr_s_q;
  logic [15:0] data_s_q;
  logic        oe_s_q, we_s_q, en_s_q;

  // FSM and datapath state
  state_t      state_q, state_d;
  logic [17:0] lat_addr_q, lat_addr_d;
  logic        oor_q, oor_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        drive_en_q, drive_en_d;
  logic [15:0] drive_data_q, drive_data_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        err_q, err_d;
  logic        mem_we;

  logic [15:0] mem [DEPTH];

  logic all_low;
  assign all_low = !en_s_q && !oe_s_q && !we_s_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_s_q <= '0;
      data_s_q <= '0;
      oe_s_q   <= 1'b1;
      we_s_q   <= 1'b1;
      en_s_q   <= 1'b1;
    end else begin
      addr_s_q <= Ram1Addr;
      data_s_q <= Ram1Data;
      oe_s_q   <= Ram1OE;
      we_s_q   <= Ram1WE;
      en_s_q   <= Ram1EN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lat_addr_q   <= '0;
      oor_q        <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      drive_en_q   <= 1'b0;
      drive_data_q <= '0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      oor_q        <= oor_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      drive_en_q   <= drive_en_d;
      drive_data_q <= drive_data_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      err_q        <= err_d;
    end
  end

  // NOTE: storage has no reset; its contents must survive rst, and
  // leaving it out of the reset network lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[lat_addr_q[DEPTH_LOG2-1:0]] <= hold_q;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    lat_addr_d   = lat_addr_q;
    oor_d        = oor_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    drive_data_d = drive_data_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    err_d        = err_q;
    mem_we       = 1'b0;

    if (all_low) begin
      // OE and WE together is illegal in any state: flag, drop, go idle.
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!en_s_q && !oe_s_q && we_s_q) begin
            lat_addr_d = addr_s_q;
            oor_d      = out_of_range(addr_s_q);
            err_d      = err_q | out_of_range(addr_s_q);
            cnt_d      = LAT_LOAD;
            state_d    = RD_WAIT;
          end else if (!en_s_q && !we_s_q && oe_s_q) begin
            lat_addr_d = addr_s_q;
            oor_d      = out_of_range(addr_s_q);
            err_d      = err_q | out_of_range(addr_s_q);
            hold_d     = data_s_q;
            state_d    = WR_HOLD;
          end
        end
        RD_WAIT: begin
          if (en_s_q || oe_s_q) begin
            state_d = IDLE;
          end else if (cnt_q == 3'd0) begin
            state_d      = RD_DRIVE;
            drive_data_d = oor_q ? 16'h0000 : mem[lat_addr_q[DEPTH_LOG2-1:0]];
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        RD_DRIVE: begin
          if (en_s_q || oe_s_q) begin
            state_d = IDLE;
          end else if (addr_s_q != lat_addr_q) begin
            // Address moved under a held read: restart the access.
            lat_addr_d = addr_s_q;
            oor_d      = out_of_range(addr_s_q);
            err_d      = err_q | out_of_range(addr_s_q);
            cnt_d      = LAT_LOAD;
            state_d    = RD_WAIT;
          end
        end
        WR_HOLD: begin
          if (en_s_q) begin
            state_d = IDLE;  // abort before WE rose: nothing written
          end else if (we_s_q) begin
            if (!oor_q) begin
              mem_we     = 1'b1;
              wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
            end
            state_d = IDLE;
          end else begin
            hold_d = data_s_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_q == RD_DRIVE && state_d != RD_DRIVE)
      rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;

    drive_en_d = (state_d == RD_DRIVE);
  end

  // Both terms are registers; the sampled WE term keeps the bus released
  // in the cycle an initiator starts a write while a read is still held.
  assign Ram1Data = (drive_en_q && we_s_q) ? drive_data_q : 16'hzzzz;

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign err      = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ram1_responder.sv
// Directed bench for ram1_responder. Two instances share all bus controls:
// u_dut (READ_LAT=1) carries most checks, u_dut4 (READ_LAT=4) the long
// latency sequence. Each data bus has a pull-up, so a released bus reads
// as 16'hFFFF; no stored test value uses that pattern.

module tb_ram1_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        oe, we, en;
  logic        tb_drive;
  logic [15:0] tb_data;

  wire  [15:0] bus1, bus4;
  logic [15:0] rd1, wr1, rd4, wr4;
  logic        err1, err4;
  logic [1:0]  st1, st4;

  int checks   = 0;
  int failures = 0;

  assign bus1 = tb_drive ? tb_data : 16'hzzzz;
  assign bus4 = tb_drive ? tb_data : 16'hzzzz;
  pullup (bus1);
  pullup (bus4);

  always #5 clk = ~clk;

  ram1_responder #(.DEPTH_LOG2(8), .READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .Ram1Addr(addr), .Ram1Data(bus1),
    .Ram1OE(oe), .Ram1WE(we), .Ram1EN(en),
    .rd_count(rd1), .wr_count(wr1), .err(err1), .state_o(st1)
  );

  ram1_responder #(.DEPTH_LOG2(8), .READ_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .Ram1Addr(addr), .Ram1Data(bus4),
    .Ram1OE(oe), .Ram1WE(we), .Ram1EN(en),
    .rd_count(rd4), .wr_count(wr4), .err(err4), .state_o(st4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d);
    addr = a; tb_data = d; tb_drive = 1'b1;
    en = 1'b0; we = 1'b0; oe = 1'b1;
    repeat (3) @(negedge clk);
    we = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1; tb_drive = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // READ_LAT=1 read on u_dut: hi-Z after edges N and N+1, data after N+2.
  task automatic do_read(input string tag, input logic [17:0] a, input logic [15:0] exp);
    addr = a; en = 1'b0; oe = 1'b0; we = 1'b1;
    @(negedge clk);
    check({tag, "_z_n0"}, bus1, 16'hFFFF);
    @(negedge clk);
    check({tag, "_z_n1"}, bus1, 16'hFFFF);
    @(negedge clk);
    check({tag, "_data"}, bus1, exp);
    en = 1'b1; oe = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_release"}, bus1, 16'hFFFF);
  endtask

  initial begin
    logic [1:0] rl4_states [6];
    rl4_states = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

    rst = 1'b0; addr = '0; oe = 1'b1; we = 1'b1; en = 1'b1;
    tb_drive = 1'b0; tb_data = '0;
    repeat (3) @(negedge clk);
    check("rst_state", st1, 2'd0);
    check("rst_rd_count", rd1, 16'd0);
    check("rst_wr_count", wr1, 16'd0);
    check("rst_err", err1, 1'b0);
    check("rst_bus", bus1, 16'hFFFF);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic write then read back.
    do_write(18'h00010, 16'hA5C3);
    check("wr1_count", wr1, 16'd1);
    do_read("rd1", 18'h00010, 16'hA5C3);
    check("rd1_count", rd1, 16'd1);
    check("rd1_err", err1, 1'b0);

    // READ_LAT=4 sequence on u_dut4.
    do_write(18'h00020, 16'h3C5A);
    check("wr2_count", wr1, 16'd2);
    addr = 18'h00020; en = 1'b0; oe = 1'b0; we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rl4_state_%0d", i), st4, rl4_states[i]);
      check($sformatf("rl4_bus_%0d", i), bus4, (i < 5) ? 16'hFFFF : 16'h3C5A);
    end
    en = 1'b1; oe = 1'b1;
    repeat (2) @(negedge clk);
    check("rl4_release", bus4, 16'hFFFF);
    check("rl4_rd_count", rd4, 16'd1);
    check("rd2_count", rd1, 16'd2);

    // Write aborted by EN rising while WE still low.
    addr = 18'h00010; tb_data = 16'hDEAD; tb_drive = 1'b1;
    en = 1'b0; we = 1'b0; oe = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    we = 1'b1; tb_drive = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_wr_count", wr1, 16'd2);
    check("abort_err", err1, 1'b0);
    check("abort_state", st1, 2'd0);
    do_read("abort_rb", 18'h00010, 16'hA5C3);

    // OE and WE low together with EN low.
    addr = 18'h00010; en = 1'b0; oe = 1'b0; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("both_err", err1, 1'b1);
    check("both_bus_a", bus1, 16'hFFFF);
    check("both_state", st1, 2'd0);
    @(negedge clk);
    check("both_bus_b", bus1, 16'hFFFF);
    en = 1'b1; oe = 1'b1; we = 1'b1;
    repeat (2) @(negedge clk);
    check("both_wr_count", wr1, 16'd2);
    check("both_rd_count", rd1, 16'd3);
    do_read("both_rb", 18'h00010, 16'hA5C3);

    // Reset pulsed while the read is being driven.
    addr = 18'h00020; en = 1'b0; oe = 1'b0; we = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_state", st1, 2'd2);
    check("pre_rst_bus", bus1, 16'h3C5A);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_bus", bus1, 16'hFFFF);
    check("mid_rst_state", st1, 2'd0);
    check("mid_rst_rd_count", rd1, 16'd0);
    check("mid_rst_wr_count", wr1, 16'd0);
    check("mid_rst_err", err1, 1'b0);
    en = 1'b1; oe = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_read("post_rst_10", 18'h00010, 16'hA5C3);
    do_read("post_rst_20", 18'h00020, 16'h3C5A);
    check("post_rst_rd_count", rd1, 16'd2);

    // Address range boundary.
    do_write(18'h000FF, 16'hBEEF);
    check("top_wr_count", wr1, 16'd1);
    check("top_err", err1, 1'b0);
    do_read("top_rb", 18'h000FF, 16'hBEEF);
    do_write(18'h00000, 16'h1111);
    check("zero_wr_count", wr1, 16'd2);
    do_write(18'h00100, 16'h7777);
    check("oor_err", err1, 1'b1);
    check("oor_wr_count", wr1, 16'd2);
    do_read("alias_rb", 18'h00000, 16'h1111);
    do_read("oor_rd", 18'h00100, 16'h0000);
    check("final_rd_count", rd1, 16'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram1_responder.md
RAM1_RESPONDER -- requirements
Module: ram1_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, sets word-address bits backed by internal storage (2^DEPTH_LOG2 x 16-bit words).
REQ-002 Parameter READ_LAT, default 1, legal 1..7, sets wait cycles between read acceptance and data drive.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 Ram1Addr  input  18  word address from the initiator.
REQ-006 Ram1Data  inout  16  data bus; the block drives it only in RD_DRIVE and is hi-Z otherwise.
REQ-007 Ram1OE  input  1  output enable, active-low.
REQ-008 Ram1WE  input  1  write enable, active-low.
REQ-009 Ram1EN  input  1  chip enable, active-low.
REQ-010 rd_count  output  16  number of completed reads, saturating.
REQ-011 wr_count  output  16  number of committed writes, saturating.
REQ-012 err  output  1  sticky protocol/range error flag.
REQ-013 state_o  output  2  current FSM state: IDLE=0, RD_WAIT=1, RD_DRIVE=2, WR_HOLD=3.

Function
REQ-014 Ram1Addr, Ram1Data, OE, WE and EN shall be registered once; the FSM shall act only on these sampled copies (addr_s, data_s, oe_s, we_s, en_s).
REQ-015 The bus driver enable and drive data shall be registers; Ram1Data shall never be driven combinationally from the inputs.
REQ-016 IDLE: en_s=0, oe_s=0, we_s=1 -> latch addr_s, load wait counter with READ_LAT-1, go to RD_WAIT.
REQ-017 IDLE: en_s=0, we_s=0, oe_s=1 -> latch addr_s, go to WR_HOLD.
REQ-018 Any state: en_s=0, oe_s=0, we_s=0 -> set err, go to IDLE, release bus, perform no write.
REQ-019 RD_WAIT: en_s=1 or oe_s=1 -> IDLE. Otherwise decrement the counter; on the edge where it is 0, go to RD_DRIVE and drive mem[latched addr].
REQ-020 Read latency: data shall be on Ram1Data after rising edge N+READ_LAT+1, where edge N is the first edge sampling OE low.
REQ-021 RD_DRIVE: on leaving, increment rd_count once (saturating at 16'hFFFF).
REQ-022 RD_DRIVE: oe_s=1 or en_s=1 -> release the bus on that edge and go to IDLE.
REQ-023 RD_DRIVE: addr_s differs from the latched address while OE/EN stay low -> release the bus, latch the new address, reload the counter, go to RD_WAIT.
REQ-024 WR_HOLD: on each edge with we_s=0, capture data_s into the write holding register.
REQ-025 WR_HOLD: we_s=1 with en_s=0 -> write the holding register to mem[latched addr], increment wr_count (saturating), go to IDLE.
REQ-026 WR_HOLD: en_s=1 before the WE rising edge -> abort, with no write, no count change and no err; go to IDLE.
REQ-027 Address bits [17:DEPTH_LOG2] nonzero on an accepted access -> set err. A read of such an address shall drive 16'h0000; a write to it shall be dropped and not counted.
REQ-028 err shall stay set until reset.
REQ-029 The block shall never drive Ram1Data while we_s=0.

Reset
REQ-030 rst low shall immediately force: state IDLE, bus hi-Z, rd_count=0, wr_count=0, err=0, oe_s/we_s/en_s=1, holding and wait registers cleared.
REQ-031 Reset asserted mid-access shall abort the access with no write, no count change and immediate bus release. Memory contents are unaffected by reset.
REQ-032 After rst rises, the first access shall be accepted no earlier than the second rising edge.

Verification
REQ-033 Write/read: write 16'hA5C3 to address 0x00010 (EN/WE low 3 cycles, then WE high), then read it (EN/OE low). Required: wr_count=1, Ram1Data=16'hA5C3 after edge N+2 (READ_LAT=1), rd_count=1 after OE rises.
REQ-034 READ_LAT=4: required first drive after edge N+5, bus hi-Z during every prior cycle, state_o sequence 0,1,1,1,1,2.
REQ-035 OE and WE both low with EN low: required err=1, bus hi-Z, no memory change, counts unchanged.
REQ-036 Write to 0x00100 with DEPTH_LOG2=8: required err=1, wr_count unchanged; a read of 0x00100 drives 16'h0000.
REQ-037 EN raised during WR_HOLD before WE rises: required no write (a readback returns the old value), wr_count unchanged, err=0.
REQ-038 rst pulsed low while in RD_DRIVE: required bus hi-Z in the same cycle, counts=0, state_o=0; data written before the reset reads back intact.
